// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, MULT/DIV EX occupancy stall,
// taken-branch flushes and saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_is_muldiv,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        branch_taken,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_en,
    output logic        id_ex_bubble,
    output logic        md_busy,
    output logic        md_abort,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_events
);

    typedef enum logic {
        RUN,
        MD_BUSY
    } state_t;

    localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] md_cnt_q, md_cnt_d;
    logic       lu;

    assign lu = (state_q == RUN) && ex_mem_read && (ex_rt != 5'd0) &&
                ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));

    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b0;
        id_ex_bubble = 1'b0;
        md_busy      = 1'b0;
        md_abort     = 1'b0;
        state_d      = state_q;
        md_cnt_d     = md_cnt_q;

        if (rst) begin
            state_d  = RUN;
            md_cnt_d = '0;
        end else if (branch_taken) begin
            pc_en        = 1'b1;
            if_id_en     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_en     = 1'b1;
            id_ex_bubble = 1'b1;
            md_abort     = (state_q == MD_BUSY);
            state_d      = RUN;
            md_cnt_d     = '0;
        end else if (state_q == MD_BUSY) begin
            md_busy  = 1'b1;
            md_cnt_d = md_cnt_q - 4'd1;
            if (md_cnt_q == 4'd1) begin
                state_d = RUN;
            end
        end else if (lu) begin
            id_ex_en     = 1'b1;
            id_ex_bubble = 1'b1;
        end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
            id_ex_en = 1'b1;
            // The op is captured into ID/EX at this edge; the remaining cycles stall.
            if (id_is_muldiv && (MULDIV_CYCLES > 1)) begin
                state_d  = MD_BUSY;
                md_cnt_d = MD_LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            md_cnt_q     <= '0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            if (!pc_en && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (branch_taken && (flush_events != '1)) begin
                flush_events <= flush_events + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized bench for pipe_hazard_ctrl against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MDC = 4;

    logic        clk = 1'b0;
    logic        rst, branch_taken, id_is_muldiv, ex_mem_read;
    logic        id_uses_rs, id_uses_rt;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, md_busy, md_abort;
    logic [31:0] stall_cycles;
    logic [15:0] flush_events;

    pipe_hazard_ctrl #(.MULDIV_CYCLES(MDC)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_muldiv(id_is_muldiv), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .branch_taken(branch_taken),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble),
        .md_busy(md_busy), .md_abort(md_abort),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: remaining MD stall cycles as a plain integer.
    int unsigned m_rem   = 0;
    logic [31:0] m_stall = '0;
    logic [15:0] m_flush = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic br, input logic md, input logic mr,
                         input logic [4:0] ert, input logic [4:0] rs, input logic urs);
        rst = r; branch_taken = br; id_is_muldiv = md; ex_mem_read = mr;
        ex_rt = ert; id_rs = rs; id_uses_rs = urs;
    endtask

    // Compare one cycle against the model, then advance through the clock edge.
    task automatic step();
        logic [6:0] e_ctrl;
        logic       hz;
        #1;
        hz = ex_mem_read && (ex_rt != 5'd0) &&
             ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
        check("stall_cycles", stall_cycles, m_stall);
        check("flush_events", {16'd0, flush_events}, {16'd0, m_flush});
        if (rst) begin
            e_ctrl = 7'b0000000;
        end else if (branch_taken) begin
            e_ctrl = {5'b11111, 1'b0, (m_rem > 0)};
        end else if (m_rem > 0) begin
            e_ctrl = 7'b0000010;
        end else if (hz) begin
            e_ctrl = 7'b0001100;
        end else begin
            e_ctrl = 7'b1101000;
        end
        check("ctrl{pc,ifid,flush,idex,bub,busy,abort}",
              {25'd0, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, md_busy, md_abort},
              {25'd0, e_ctrl});
        @(posedge clk);
        if (rst) begin
            m_rem = 0; m_stall = '0; m_flush = '0;
        end else begin
            if (!e_ctrl[6] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (branch_taken) begin
                if (m_flush != 16'hFFFF) m_flush = m_flush + 1;
                m_rem = 0;
            end else if (m_rem > 0) begin
                m_rem = m_rem - 1;
            end else if (!hz && id_is_muldiv) begin
                m_rem = MDC - 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 5'd0, 5'd0, 0);
            step();
        end
    endtask

    initial begin
        id_rt = 5'd0; id_uses_rt = 1'b0;
        drive(1, 1, 0, 0, 5'd0, 5'd0, 0);
        @(negedge clk);

        // Reset held with branch_taken asserted
        step(); step();
        idle(1);

        // Load-use hazard, then the same with ex_rt = 0
        drive(0, 0, 0, 1, 5'd8, 5'd8, 1); step();
        idle(1);
        check("stall_after_lu", stall_cycles, 32'd1);
        drive(0, 0, 0, 1, 5'd0, 5'd0, 1); step();
        check("stall_lu_r0", stall_cycles, 32'd1);

        // Single MULT
        drive(0, 0, 1, 0, 5'd0, 5'd0, 0); step();
        idle(4);
        check("stall_single_md", stall_cycles, 32'd4);

        // Back-to-back MULT: second op waits in ID through the first's stall
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0, 5'd0, 5'd0, 0); step();
        end
        idle(4);
        check("stall_b2b_md", stall_cycles, 32'd10);

        // Abort on 2nd busy cycle, then abort on the final busy cycle
        drive(0, 0, 1, 0, 5'd0, 5'd0, 0); step();
        idle(1);
        drive(0, 1, 0, 0, 5'd0, 5'd0, 0); step();
        idle(1);
        check("flush_after_abort", {16'd0, flush_events}, 32'd1);
        drive(0, 0, 1, 0, 5'd0, 5'd0, 0); step();
        idle(2);
        drive(0, 1, 0, 0, 5'd0, 5'd0, 0); step();
        idle(1);

        // lu + muldiv + branch together: flush only
        drive(0, 1, 1, 1, 5'd8, 5'd8, 1); step();
        idle(2);

        // Reset in the middle of MD_BUSY
        drive(0, 0, 1, 0, 5'd0, 5'd0, 0); step();
        idle(1);
        drive(1, 0, 0, 0, 5'd0, 5'd0, 0); step();
        idle(2);

        // Saturation of both counters from preloaded values
        force dut.stall_cycles = 32'hFFFF_FFFE;
        force dut.flush_events = 16'hFFFE;
        #1;
        release dut.stall_cycles;
        release dut.flush_events;
        m_stall = 32'hFFFF_FFFE;
        m_flush = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 5'd9, 5'd9, 1); step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 5'd0, 5'd0, 0); step();
        end
        check("stall_sat", stall_cycles, 32'hFFFF_FFFF);
        check("flush_sat", {16'd0, flush_events}, 32'h0000_FFFF);

        // Randomized traffic
        drive(1, 0, 0, 0, 5'd0, 5'd0, 0); step();
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            id_rt      = 5'($urandom_range(0, 3));
            id_uses_rt = 1'($urandom_range(0, 1));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. Generates the PC, IF/ID and ID/EX enables and bubble/flush controls: `id_ex_en` drives the ID/EX register's `en_reg`, and `id_ex_bubble` zeroes the 9-bit control word entering ID/EX. It covers three cases:
- load-use hazards: single-cycle bubble;
- multi-cycle MULT/DIV occupancy of EX: FSM stall;
- taken-branch flushes.

It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- MULDIV_CYCLES, 4: number of cycles a MULT/DIV occupies EX; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_is_muldiv  in  1  ID instruction is MULT/MULTU/DIV/DIVU
- ex_mem_read  in  1  memory-read bit of the ID/EX M control field (load in EX)
- ex_rt  in  5  ID_EX_rt (load destination)
- branch_taken  in  1  taken branch/jump resolved this cycle; one-cycle pulse per branch
- pc_en  out  1  PC register load enable
- if_id_en  out  1  IF/ID register enable
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_en  out  1  ID/EX register enable (en_reg)
- id_ex_bubble  out  1  force the ID/EX control word to 0 on this load
- md_busy  out  1  MULT/DIV occupying EX, stall phase
- md_abort  out  1  one-cycle pulse: in-flight MULT/DIV squashed by a branch
- stall_cycles  out  32  count of cycles with pc_en=0, saturating
- flush_events  out  16  count of branch_taken cycles, saturating

## Operation
- States: RUN and MD_BUSY. A down-counter `md_cnt` is sized for MULDIV_CYCLES-1.
- Load-use hazard (`lu`), evaluated combinationally in RUN only:
  - lu = ex_mem_read & (ex_rt != 0) & ((id_uses_rs & id_rs == ex_rt) | (id_uses_rt & id_rt == ex_rt)).
- Output priority, highest first: rst, then branch_taken, then MD_BUSY, then lu, then normal.
  - branch_taken: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_en=1, id_ex_bubble=1. The next state is RUN and md_cnt is cleared. If the current state is MD_BUSY, md_abort=1.
  - MD_BUSY (no branch): pc_en=0, if_id_en=0, id_ex_en=0, md_busy=1, bubble and flush both 0. md_cnt decrements. When md_cnt==1 on this cycle, the next state is RUN.
  - lu in RUN: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_bubble=1. The bubble occupies EX next cycle, so lu clears by itself and the stall lasts exactly 1 cycle.
  - Normal RUN: all enables 1, bubble, flush and md flags 0.
- MULT/DIV entry:
  - Condition: in RUN, with id_is_muldiv=1, no lu and no branch_taken, the op is latched into ID/EX at this edge.
  - If MULDIV_CYCLES>1: next state is MD_BUSY and md_cnt loads MULDIV_CYCLES-1.
  - If MULDIV_CYCLES=1: the state stays RUN.
- id_is_muldiv together with lu: lu wins. The MULT/DIV stays in ID and re-enters next cycle.
- Counters:
  - stall_cycles increments on every cycle with pc_en=0 and holds at 32'hFFFFFFFF.
  - flush_events increments on every branch_taken cycle and holds at 16'hFFFF.
  - Both counters are 0 after reset.

## Timing
- Reset, applied at the clock edge, sets: state=RUN, md_cnt=0, stall_cycles=0, flush_events=0.
  - While rst=1, outputs are forced to: pc_en=0, if_id_en=0, id_ex_en=0, if_id_flush=0, id_ex_bubble=0, md_busy=0, md_abort=0.
  - The first cycle after rst deasserts is in RUN.
- Reset mid-MD_BUSY returns to RUN immediately; no md_abort pulse is produced.
- All enables, flush, bubble, md_busy and md_abort are combinational from the current state and inputs: zero-cycle latency into the same edge. State and counters are registered.
- MULT/DIV occupies EX for exactly MULDIV_CYCLES cycles:
  - Cycles 1..MULDIV_CYCLES-1 are the MD_BUSY stall.
  - Cycle MULDIV_CYCLES is RUN with all enables 1, so the result advances.
- Back-to-back MULT/DIV: the second op enters on the RUN cycle that ends the first and starts a fresh MD_BUSY.
- branch_taken on the final MD_BUSY cycle (md_cnt==1) still produces md_abort=1.

## Test plan
- Reset: hold rst for 2 cycles with branch_taken=1 -> all control outputs 0, counters 0. First cycle after release: pc_en=if_id_en=id_ex_en=1.
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8, id_uses_rs=1 -> exactly one cycle of pc_en=0, if_id_en=0, id_ex_bubble=1, id_ex_en=1. stall_cycles=1. Repeat with ex_rt=0 -> no stall.
- MULT/DIV with MULDIV_CYCLES=4: one MULT in ID -> md_busy=1 and id_ex_en=0 for 3 cycles, then RUN. stall_cycles=3. Back-to-back pair -> 6 stall cycles total.
- Abort: branch_taken during the 2nd MD_BUSY cycle -> md_abort=1, if_id_flush=1, id_ex_bubble=1, pc_en=1 that cycle. Next cycle RUN, md_busy=0, flush_events=1.
- Simultaneous: lu=1, id_is_muldiv=1 and branch_taken=1 in the same cycle -> flush behaviour only, no MD_BUSY entry, stall_cycles unchanged.
- Saturation: force stall_cycles near 32'hFFFFFFFE, then 3 stall cycles -> holds at 32'hFFFFFFFF. flush_events holds at 16'hFFFF.
